snake_move_scheduler: RTL and testbench

//  Sequences the snake datapath. It generates the move tick, runs a req/ack handshake

---
 rtl/snake_move_scheduler.sv | 148 ++++++++++++++
 tb/tb_snake_move_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_scheduler.sv
// Paces snake moves, runs the move_req/move_ack handshake with the body-shift datapath,
// strobes the collision check after each completed move and tracks speed level from apples.
module snake_move_scheduler #(
  parameter int BASE_PERIOD      = 25_000_000,
  parameter int STEP             = 2_500_000,
  parameter int LEVELS_MAX       = 7,
  parameter int APPLES_PER_LEVEL = 5,
  parameter int ACK_TIMEOUT      = 255
) (
  input  logic        CLK_50M,
  input  logic        RSTn,
  input  logic [1:0]  game_status,
  input  logic        restart,
  input  logic        add_cube,
  input  logic        move_ack,
  output logic        move_req,
  output logic        check_strobe,
  output logic [2:0]  speed_level,
  output logic [15:0] move_count,
  output logic        fault
);
  // state | meaning
  // IDLE  | not playing, divider parked at 0
  // WAIT  | counting toward the next move tick
  // REQ   | move_req high, waiting for move_ack or timeout
  // CHK   | one-cycle collision-check strobe

  localparam int DIV_W = $clog2(BASE_PERIOD);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int APL_W = $clog2(APPLES_PER_LEVEL + 1);
  localparam logic [1:0] GS_PLAY = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, REQ, CHK} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [APL_W-1:0]  apple_cnt_q, apple_cnt_d;
  logic [2:0]        speed_level_q, speed_level_d;
  logic [15:0]       move_count_q, move_count_d;
  logic              move_req_q, move_req_d;
  logic              fault_q, fault_d;
  logic              play, tick, acked, timed_out;
  logic [31:0]       tick_limit;

  assign play = (game_status == GS_PLAY);

  // Limit follows the live speed level, so a level-up mid-count takes effect at once.
  assign tick_limit = 32'(BASE_PERIOD) - 32'(speed_level_q) * 32'(STEP) - 32'd1;
  assign tick       = (32'(div_q) >= tick_limit);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    tmo_d      = tmo_q;
    move_req_d = move_req_q;
    acked      = 1'b0;
    timed_out  = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (play) state_d = WAIT;
      end
      WAIT: begin
        if (!play) begin
          div_d   = '0;
          state_d = IDLE;
        end else if (tick) begin
          div_d      = '0;
          tmo_d      = '0;
          move_req_d = 1'b1;
          state_d    = REQ;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      REQ: begin
        // The handshake always completes, even if play ends while it is pending.
        if (move_ack) begin
          move_req_d = 1'b0;
          acked      = 1'b1;
          state_d    = CHK;
        end else if (tmo_q >= TMO_W'(ACK_TIMEOUT - 1)) begin
          move_req_d = 1'b0;
          timed_out  = 1'b1;
          state_d    = play ? WAIT : IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CHK: state_d = play ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    apple_cnt_d   = apple_cnt_q;
    speed_level_d = speed_level_q;
    move_count_d  = move_count_q;
    fault_d       = fault_q;
    if (restart) begin
      apple_cnt_d   = '0;
      speed_level_d = '0;
      move_count_d  = '0;
      fault_d       = 1'b0;
    end else begin
      if (add_cube) begin
        if (apple_cnt_q == APL_W'(APPLES_PER_LEVEL - 1)) begin
          apple_cnt_d = '0;
          if (speed_level_q < 3'(LEVELS_MAX)) speed_level_d = speed_level_q + 1'b1;
        end else begin
          apple_cnt_d = apple_cnt_q + 1'b1;
        end
      end
      if (acked && (move_count_q != 16'hFFFF)) move_count_d = move_count_q + 1'b1;
      if (timed_out) fault_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= IDLE;
      div_q         <= '0;
      tmo_q         <= '0;
      apple_cnt_q   <= '0;
      speed_level_q <= '0;
      move_count_q  <= '0;
      move_req_q    <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      tmo_q         <= tmo_d;
      apple_cnt_q   <= apple_cnt_d;
      speed_level_q <= speed_level_d;
      move_count_q  <= move_count_d;
      move_req_q    <= move_req_d;
      fault_q       <= fault_d;
    end
  end

  assign move_req     = move_req_q;
  assign check_strobe = (state_q == CHK);
  assign speed_level  = speed_level_q;
  assign move_count   = move_count_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Bench for snake_move_scheduler: directed timing scenarios plus randomized traffic,
// every cycle compared against an event-level model of the move scheduler.
module tb_snake_move_scheduler;
  localparam int P_BASE = 20;
  localparam int P_STEP = 4;
  localparam int P_LMAX = 3;
  localparam int P_APL  = 2;
  localparam int P_TMO  = 4;
  localparam logic [1:0] GS_PLAY = 2'b10;
  localparam logic [1:0] GS_DIE  = 2'b11;

  logic        clk_sys = 1'b0;
  logic        rst_b = 1'b0;
  logic [1:0]  game_status = 2'b00;
  logic        restart = 1'b0;
  logic        add_cube = 1'b0;
  logic        move_ack = 1'b0;
  logic        move_req, check_strobe, fault;
  logic [2:0]  speed_level;
  logic [15:0] move_count;

  int n_checks = 0;
  int n_pass = 0;
  int ack_mode = 0;  // 0 none, 1 ack the cycle after req, 2 random

  // reference model: totals since restart plus the move-pacing phase
  bit m_req, m_strobe, m_waiting, m_fault;
  int m_waited, m_req_age, m_apples, m_moves;

  snake_move_scheduler #(
    .BASE_PERIOD(P_BASE), .STEP(P_STEP), .LEVELS_MAX(P_LMAX),
    .APPLES_PER_LEVEL(P_APL), .ACK_TIMEOUT(P_TMO)
  ) dut (
    .CLK_50M(clk_sys), .RSTn(rst_b), .game_status(game_status), .restart(restart),
    .add_cube(add_cube), .move_ack(move_ack), .move_req(move_req),
    .check_strobe(check_strobe), .speed_level(speed_level), .move_count(move_count),
    .fault(fault)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic int exp_level();
    int l;
    l = m_apples / P_APL;
    return (l > P_LMAX) ? P_LMAX : l;
  endfunction

  task automatic model_reset();
    m_req = 0; m_strobe = 0; m_waiting = 0; m_fault = 0;
    m_waited = 0; m_req_age = 0; m_apples = 0; m_moves = 0;
  endtask

  task automatic model_step();
    bit play, moved, timed_out;
    int period;
    if (!rst_b) begin
      model_reset();
      return;
    end
    play = (game_status == GS_PLAY);
    period = P_BASE - exp_level() * P_STEP;
    moved = 0;
    timed_out = 0;
    if (m_req) begin
      if (move_ack) begin
        m_req = 0; m_strobe = 1; moved = 1;
      end else if (m_req_age >= P_TMO) begin
        m_req = 0; timed_out = 1; m_waiting = play; m_waited = 0;
      end else m_req_age++;
    end else if (m_strobe) begin
      m_strobe = 0; m_waiting = play; m_waited = 0;
    end else if (m_waiting) begin
      if (!play) m_waiting = 0;
      else if (m_waited + 1 >= period) begin
        m_waiting = 0; m_req = 1; m_req_age = 1;
      end else m_waited++;
    end else if (play) begin
      m_waiting = 1; m_waited = 0;
    end
    if (restart) begin
      m_apples = 0; m_moves = 0; m_fault = 0;
    end else begin
      if (add_cube) m_apples++;
      if (moved && m_moves < 65535) m_moves++;
      if (timed_out) m_fault = 1;
    end
  endtask

  task automatic compare_all();
    chk("move_req", move_req, m_req);
    chk("check_strobe", check_strobe, m_strobe);
    chk("speed_level", speed_level, exp_level());
    chk("move_count", move_count, m_moves);
    chk("fault", fault, m_fault);
  endtask

  task automatic cycle();
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    compare_all();
    case (ack_mode)
      1: move_ack = move_req;
      2: move_ack = ($urandom_range(0, 9) < 4);
      default: move_ack = 1'b0;
    endcase
  endtask

  task automatic pulse_add();
    add_cube = 1'b1;
    cycle();
    add_cube = 1'b0;
  endtask

  // edges until the next rising edge of move_req (200 means it never came)
  task automatic next_rise(output int n);
    logic prev;
    n = 0;
    while (n < 200) begin
      prev = move_req;
      cycle();
      n++;
      if (move_req && !prev) break;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, h, rises, strobes;
    model_reset();
    cycle();
    cycle();
    chk("reset_req", move_req, 0);
    chk("reset_count", move_count, 0);
    rst_b = 1'b1;

    // T1: first tick after PLAY, then period+2 spacing with prompt acks
    ack_mode = 1;
    game_status = GS_PLAY;
    cycle();
    next_rise(n);
    chk("t1_first_req", n, P_BASE);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin
        next_rise(n);
        chk("t1_gap", n + 1, P_BASE + 2);
      end
      cycle();
      chk("t1_strobe", check_strobe, 1);
      chk("t1_count", move_count, k);
    end

    // T2: level climbs every two apples and saturates
    for (int i = 1; i <= 8; i++) begin
      pulse_add();
      cycle();
      if (i % 2 == 0) chk("t2_level", speed_level, (i / 2 > P_LMAX) ? P_LMAX : i / 2);
    end
    next_rise(n);
    next_rise(n);
    chk("t2_gap", n, P_BASE - P_LMAX * P_STEP + 2);

    // T3: unanswered request times out and sets fault
    ack_mode = 0;
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    next_rise(n);
    chk("t3_sync", n < 200, 1);
    h = 0;
    while (move_req && h < 50) begin
      h++;
      cycle();
    end
    chk("t3_req_high", h, P_TMO);
    chk("t3_fault", fault, 1);
    chk("t3_no_strobe", check_strobe, 0);
    next_rise(n);
    chk("t3_next_req", n, P_BASE);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    chk("t3_fault_clr", fault, 0);

    // T4: leaving PLAY mid-handshake still completes, then idles
    next_rise(n);
    chk("t4_sync", n < 200, 1);
    game_status = GS_DIE;
    cycle();
    move_ack = 1'b1;
    cycle();
    chk("t4_strobe", check_strobe, 1);
    rises = 0;
    strobes = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (move_req) rises++;
      if (check_strobe) strobes++;
    end
    chk("t4_no_req", rises, 0);
    chk("t4_no_strobe", strobes, 0);

    // T5: restart beats a simultaneous add_cube
    for (int i = 0; i < 4; i++) pulse_add();
    chk("t5_level2", speed_level, 2);
    chk("t5_count_pre", move_count, 1);
    restart = 1'b1;
    add_cube = 1'b1;
    cycle();
    restart = 1'b0;
    add_cube = 1'b0;
    chk("t5_level", speed_level, 0);
    chk("t5_count", move_count, 0);
    pulse_add();
    chk("t5_apple_cleared", speed_level, 0);
    pulse_add();
    chk("t5_level_up", speed_level, 1);

    // T6: async reset during REQ, resume from IDLE
    game_status = GS_PLAY;
    next_rise(n);
    chk("t6_sync", move_req, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("t6_req", move_req, 0);
    chk("t6_strobe", check_strobe, 0);
    chk("t6_level", speed_level, 0);
    chk("t6_count", move_count, 0);
    chk("t6_fault", fault, 0);
    model_reset();
    for (int i = 0; i < 3; i++) cycle();
    rst_b = 1'b1;
    next_rise(n);
    chk("t6_resume", n, P_BASE + 1);

    // randomized traffic
    ack_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      game_status = ($urandom_range(0, 99) < 85) ? GS_PLAY : 2'($urandom_range(0, 3));
      restart = ($urandom_range(0, 99) < 2);
      add_cube = ($urandom_range(0, 99) < 15);
      cycle();
    end
    restart = 1'b0;
    add_cube = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
